pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Reset and lock sequencer for the video PLL (50 MHz refclk in; 25.2 MHz pixel and 74.1 MHz outputs). It runs in the `refclk` domain and does four things:
- drives the PLL reset pulse;
- waits for and qualifies `locked`, with a timeout and a bounded number of retries;
- holds the downstream clock domains in reset until lock has been stable;
- re-sequences automatically on loss of lock.

It sits between the top-level reset/clock pins and the PLL wrapper.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, default 10: length of the PLL reset pulse in refclk cycles (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 50000: maximum cycles spent in WAIT_LOCK per attempt (≥1); 1 ms at 50 MHz.
- `LOCK_STABLE_CYCLES`, default 1024: cycles `locked` must stay high before release (≥1).
- `MAX_ATTEMPTS`, default 3: lock attempts before FAULT (≥1).

Ports:
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `pll_locked` in 1: PLL `locked`, asynchronous; passes through a 2-flop synchronizer (flops reset to 0).
- `restart` in 1: single-cycle request to re-run the full sequence.
- `pll_rst` out 1: reset to the PLL.
- `domain_rst` out 1: active-high reset for the downstream domains.
- `ready` out 1: PLL locked and qualified.
- `fault` out 1: all attempts exhausted.
- `state` out 3: current state encoding, for debug.
- `lock_loss_count` out 8: saturating count of lock losses while in RUN.

## Operation
- States and encodings: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4.
- Outputs are decoded from the state register only:
  - `pll_rst` = RESET_PLL or FAULT.
  - `domain_rst` = not RUN.
  - `ready` = RUN.
  - `fault` = FAULT.
- RESET_PLL: hold for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK. The timeout timer clears on entry to WAIT_LOCK.
- WAIT_LOCK:
  - `lock_s`=1: go to STABILIZE.
  - Timer reaches LOCK_TIMEOUT_CYCLES−1 with `lock_s`=0 (timeout): if attempt+1 == MAX_ATTEMPTS, go to FAULT. Otherwise increment attempt and go to RESET_PLL.
- STABILIZE:
  - `lock_s`=0: go to WAIT_LOCK with the timer cleared. This does not consume an attempt.
  - After LOCK_STABLE_CYCLES consecutive cycles with `lock_s`=1: go to RUN and clear attempt.
- RUN: `lock_s`=0 increments `lock_loss_count` (saturating at 255) and goes to RESET_PLL.
- FAULT: terminal state. Exit only via `rst` or `restart`.
- `restart`=1 in any state: go to RESET_PLL next cycle and clear attempt and all timers. `lock_loss_count` is unchanged.
- Priority: `rst` > `restart` > state transitions.
- Counter widths are $clog2(param+1). All counters compare against param−1 and never wrap.

## Timing
- Reset values: state=RESET_PLL, `pll_rst`=1, `domain_rst`=1, `ready`=0, `fault`=0, `lock_loss_count`=0, synchronizer=0, attempt=0.
- Counting cycle 0 as the first cycle after `rst` deasserts, `pll_rst` is high for cycles 0..RST_PULSE_CYCLES−1.
- `pll_locked` edge to `lock_s`: 2 cycles. `lock_s` to a state change: 1 cycle.
- The STABILIZE→RUN transition occurs LOCK_STABLE_CYCLES cycles after STABILIZE entry.
- `pll_locked` falling in RUN causes `ready`=0, `domain_rst`=1 and `pll_rst`=1 on the 3rd edge after the fall.
- `restart` with `rst` low gives `pll_rst`=1 on the next edge.

## Configuration
- `PLL_SEQ_STATS_EN` defined: `lock_loss_count` is implemented as specified.
- Not defined: `lock_loss_count` is tied to 8'd0, its counter is not synthesized, and FSM behaviour is otherwise identical.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_ATTEMPTS=2.
- `pll_locked`=1 held, `rst` released -> `pll_rst`=1 in cycles 0–3; state=1 at cycle 4 and 2 at cycle 5; `ready`=1 and `domain_rst`=0 from cycle 13.
- `pll_locked`=0 held -> `pll_rst` pulses at cycles 0–3 and 24–27; `fault`=1 and state=4 from cycle 48; `pll_rst` stays 1.
- Reach STABILIZE, then drop `pll_locked` for 1 cycle -> state returns to 1 with no `pll_rst` pulse; `ready` only after 8 further stable cycles.
- In RUN, drop `pll_locked` -> 3 edges later `ready`=0, `pll_rst`=1 for 4 cycles, `lock_loss_count`=1; the count stays 0 with `PLL_SEQ_STATS_EN` undefined.
- In FAULT, pulse `restart` -> next cycle state=0, `fault`=0; with `pll_locked`=1, `ready`=1 after 4+1+8 cycles.
- Assert `rst` and `restart` together mid-RUN -> all reset values next cycle, including `lock_loss_count`=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Reset and lock sequencer for the video PLL, running entirely in the refclk domain.
// Optional build macro PLL_SEQ_STATS_EN enables the saturating lock_loss_count statistic.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_ATTEMPTS        = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       domain_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] lock_loss_count
);

    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [AW-1:0] ATTEMPT_LAST = AW'(MAX_ATTEMPTS - 1);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0]   timeout_cnt_q, timeout_cnt_d;
    logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
    logic [AW-1:0]   attempt_q, attempt_d;
    logic            lock_s;

    assign lock_s  = sync2_q;
    assign sync1_d = pll_locked;
    assign sync2_d = sync1_q;

    // Each timer only advances in its own state, so leaving a state clears it.
    always_comb begin
        state_d       = state_q;
        pulse_cnt_d   = '0;
        timeout_cnt_d = '0;
        stable_cnt_d  = '0;
        attempt_d     = attempt_q;
        if (restart) begin
            state_d   = ST_RESET_PLL;
            attempt_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + PW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABILIZE;
                    end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                        if (attempt_q == ATTEMPT_LAST) begin
                            state_d = ST_FAULT;
                        end else begin
                            attempt_d = attempt_q + AW'(1);
                            state_d   = ST_RESET_PLL;
                        end
                    end else begin
                        timeout_cnt_d = timeout_cnt_q + TW'(1);
                    end
                end
                ST_STABILIZE: begin
                    // A glitch here goes back to waiting without costing an attempt.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (stable_cnt_q == STABLE_LAST) begin
                        state_d   = ST_RUN;
                        attempt_d = '0;
                    end else begin
                        stable_cnt_d = stable_cnt_q + SW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_RESET_PLL;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                end
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= ST_RESET_PLL;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            pulse_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            stable_cnt_q  <= '0;
            attempt_q     <= '0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            pulse_cnt_q   <= pulse_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            stable_cnt_q  <= stable_cnt_d;
            attempt_q     <= attempt_d;
        end
    end

`ifdef PLL_SEQ_STATS_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (!restart && state_q == ST_RUN && !lock_s && loss_cnt_q != 8'hFF) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = 8'd0;
`endif

    assign pll_rst    = (state_q == ST_RESET_PLL) || (state_q == ST_FAULT);
    assign domain_rst = (state_q != ST_RUN);
    assign ready      = (state_q == ST_RUN);
    assign fault      = (state_q == ST_FAULT);
    assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: vector tables for the lock/no-lock
// sequences plus hand-written sequences for glitch, lock loss, restart and reset.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       domain_rst;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [7:0] lock_loss_count;

`ifdef PLL_SEQ_STATS_EN
    localparam int LOSS_ONE = 1;
`else
    localparam int LOSS_ONE = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int   cyc;
        int   st;
        bit   prst;
        bit   drst;
        bit   rdy;
        bit   flt;
    } vec_t;

    vec_t vec_lock[7];
    vec_t vec_nolock[10];

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_ATTEMPTS       (2)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .restart        (restart),
        .pll_rst        (pll_rst),
        .domain_rst     (domain_rst),
        .ready          (ready),
        .fault          (fault),
        .state          (state),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int c, int s, bit p, bit d, bit r, bit f);
        vec_t v;
        v.cyc  = c;
        v.st   = s;
        v.prst = p;
        v.drst = d;
        v.rdy  = r;
        v.flt  = f;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Outputs only move on posedge, so negedge sampling sees settled values.
    task automatic tick();
        @(negedge refclk);
        cyc++;
    endtask

    task automatic run_to(int n);
        while (cyc < n) tick();
    endtask

    // Leaves the bench in cycle 0: the first cycle whose closing edge sees rst low.
    task automatic do_reset();
        @(negedge refclk);
        rst = 1'b1;
        restart = 1'b0;
        repeat (3) @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_vec(string tag, vec_t v);
        run_to(v.cyc);
        check({tag, ".state"},      int'(state),      v.st);
        check({tag, ".pll_rst"},    int'(pll_rst),    int'(v.prst));
        check({tag, ".domain_rst"}, int'(domain_rst), int'(v.drst));
        check({tag, ".ready"},      int'(ready),      int'(v.rdy));
        check({tag, ".fault"},      int'(fault),      int'(v.flt));
    endtask

    initial begin
        bit saw_prst;

        vec_lock[0] = mk(0,  0, 1, 1, 0, 0);
        vec_lock[1] = mk(3,  0, 1, 1, 0, 0);
        vec_lock[2] = mk(4,  1, 0, 1, 0, 0);
        vec_lock[3] = mk(5,  2, 0, 1, 0, 0);
        vec_lock[4] = mk(12, 2, 0, 1, 0, 0);
        vec_lock[5] = mk(13, 3, 0, 0, 1, 0);
        vec_lock[6] = mk(15, 3, 0, 0, 1, 0);

        vec_nolock[0] = mk(0,  0, 1, 1, 0, 0);
        vec_nolock[1] = mk(3,  0, 1, 1, 0, 0);
        vec_nolock[2] = mk(4,  1, 0, 1, 0, 0);
        vec_nolock[3] = mk(23, 1, 0, 1, 0, 0);
        vec_nolock[4] = mk(24, 0, 1, 1, 0, 0);
        vec_nolock[5] = mk(27, 0, 1, 1, 0, 0);
        vec_nolock[6] = mk(28, 1, 0, 1, 0, 0);
        vec_nolock[7] = mk(47, 1, 0, 1, 0, 0);
        vec_nolock[8] = mk(48, 4, 1, 1, 0, 1);
        vec_nolock[9] = mk(55, 4, 1, 1, 0, 1);

        // Clean lock with pll_locked held high through reset.
        pll_locked = 1'b1;
        do_reset();
        check("reset.loss_count", int'(lock_loss_count), 0);
        for (int i = 0; i < 7; i++) check_vec("lock", vec_lock[i]);

        // No lock at all: two attempts then FAULT.
        pll_locked = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) check_vec("nolock", vec_nolock[i]);

        // One-cycle glitch during STABILIZE.
        pll_locked = 1'b1;
        do_reset();
        run_to(6);
        check("glitch.pre_state", int'(state), 2);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        saw_prst = 1'b0;
        while (cyc < 17) begin
            tick();
            if (pll_rst) saw_prst = 1'b1;
            if (cyc == 8)  check("glitch.c8_state", int'(state), 2);
            if (cyc == 9)  check("glitch.c9_state", int'(state), 1);
            if (cyc == 10) check("glitch.c10_state", int'(state), 2);
        end
        check("glitch.no_pll_rst", int'(saw_prst), 0);
        check("glitch.c17_ready", int'(ready), 0);
        run_to(18);
        check("glitch.c18_ready", int'(ready), 1);
        check("glitch.c18_state", int'(state), 3);

        // Lock loss in RUN at cycle 20, then no relock through to FAULT.
        run_to(20);
        pll_locked = 1'b0;
        run_to(22);
        check("loss.c22_ready", int'(ready), 1);
        run_to(23);
        check("loss.c23_ready", int'(ready), 0);
        check("loss.c23_domain_rst", int'(domain_rst), 1);
        check("loss.c23_pll_rst", int'(pll_rst), 1);
        check("loss.c23_count", int'(lock_loss_count), LOSS_ONE);
        run_to(26);
        check("loss.c26_pll_rst", int'(pll_rst), 1);
        run_to(27);
        check("loss.c27_pll_rst", int'(pll_rst), 0);
        check("loss.c27_state", int'(state), 1);
        run_to(70);
        check("loss.c70_state", int'(state), 1);
        run_to(71);
        check("loss.c71_state", int'(state), 4);
        check("loss.c71_fault", int'(fault), 1);

        // FAULT holds even once lock returns; restart leaves it.
        pll_locked = 1'b1;
        run_to(75);
        check("fault.terminal_state", int'(state), 4);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart.state", int'(state), 0);
        check("restart.fault", int'(fault), 0);
        check("restart.pll_rst", int'(pll_rst), 1);
        check("restart.count_kept", int'(lock_loss_count), LOSS_ONE);
        run_to(88);
        check("restart.c88_ready", int'(ready), 0);
        run_to(89);
        check("restart.c89_ready", int'(ready), 1);

        // Restart from RUN raises pll_rst on the next edge.
        run_to(92);
        check("run_restart.pre_pll_rst", int'(pll_rst), 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("run_restart.state", int'(state), 0);
        check("run_restart.pll_rst", int'(pll_rst), 1);
        check("run_restart.count_kept", int'(lock_loss_count), LOSS_ONE);
        run_to(106);
        check("run_restart.c106_ready", int'(ready), 1);

        // rst beats restart and clears everything including the statistic.
        run_to(108);
        rst = 1'b1;
        restart = 1'b1;
        tick();
        check("rst.state", int'(state), 0);
        check("rst.pll_rst", int'(pll_rst), 1);
        check("rst.domain_rst", int'(domain_rst), 1);
        check("rst.ready", int'(ready), 0);
        check("rst.fault", int'(fault), 0);
        check("rst.count", int'(lock_loss_count), 0);
        restart = 1'b0;
        rst = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
